// File: rtl/lp_pd_sequencer.sv
// Per-domain power-down / power-up sequencer: isolation, retention save, switch
// control with ack timeout, then restore and de-isolation on the way back up.
module lp_pd_lane #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sleep_req_i,
    input  logic       wake_req_i,
    input  logic       ack_i,
    input  logic       err_clr_i,
    output logic       pwr_en_o,
    output logic       iso_en_o,
    output logic       save_o,
    output logic       restore_o,
    output logic [2:0] state_o,
    output logic       err_o,
    output logic       busy_o
);
    typedef enum logic [2:0] {
        ST_ON = 3'd0, ST_ISO = 3'd1, ST_SAVE = 3'd2, ST_PDOWN = 3'd3,
        ST_OFF = 3'd4, ST_PUP = 3'd5, ST_RESTORE = 3'd6, ST_DEISO = 3'd7
    } state_t;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(TIMEOUT_CYC);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, set_err;
    logic          pwr_en_q, iso_en_q, save_q, restore_q, busy_q;

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        unique case (state_q)
            ST_ON:      if (sleep_req_i) state_d = ST_ISO;
            ST_ISO:     if (cnt_q == SETTLE_LAST) state_d = ST_SAVE;
            ST_SAVE:    if (cnt_q == SETTLE_LAST) state_d = ST_PDOWN;
            ST_PDOWN: begin
                if (!ack_i) begin
                    state_d = ST_OFF;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_OFF;
                    set_err = 1'b1;
                end
            end
            ST_OFF:     if (wake_req_i) state_d = ST_PUP;
            ST_PUP: begin
                if (ack_i) begin
                    state_d = ST_RESTORE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_OFF;
                    set_err = 1'b1;
                end
            end
            ST_RESTORE: if (cnt_q == SETTLE_LAST) state_d = ST_DEISO;
            ST_DEISO:   if (cnt_q == SETTLE_LAST) state_d = ST_ON;
            default:    state_d = ST_ON;
        endcase
        // Cleared on every entry, parked at CNT_MAX so long stays in ON/OFF never wrap.
        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + 1'b1;
        err_d = set_err | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ON;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            pwr_en_q  <= 1'b1;
            iso_en_q  <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            pwr_en_q  <= (state_d != ST_PDOWN) && (state_d != ST_OFF);
            iso_en_q  <= (state_d != ST_ON);
            save_q    <= (state_d == ST_SAVE);
            restore_q <= (state_d == ST_RESTORE);
            busy_q    <= (state_d != ST_ON) && (state_d != ST_OFF);
        end
    end

    assign pwr_en_o  = pwr_en_q;
    assign iso_en_o  = iso_en_q;
    assign save_o    = save_q;
    assign restore_o = restore_q;
    assign state_o   = state_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
endmodule

module lp_pd_sequencer #(
    parameter int NUM_PD      = 4,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  upf_clk,
    input  logic                  soc_reset,
    input  logic [NUM_PD-1:0]     soc_sleep_req,
    input  logic [NUM_PD-1:0]     soc_wake_req,
    input  logic [NUM_PD-1:0]     soc_pwr_ack,
    input  logic [NUM_PD-1:0]     soc_err_clr,
    output logic [NUM_PD-1:0]     soc_pwr_en,
    output logic [NUM_PD-1:0]     soc_iso_en,
    output logic [NUM_PD-1:0]     soc_save,
    output logic [NUM_PD-1:0]     soc_restore,
    output logic [3*NUM_PD-1:0]   soc_pd_state,
    output logic [NUM_PD-1:0]     soc_err,
    output logic                  soc_busy
);
    logic [NUM_PD-1:0] busy_w;

    for (genvar g = 0; g < NUM_PD; g++) begin : g_pd
        lp_pd_lane #(
            .SETTLE_CYC (SETTLE_CYC),
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_lane (
            .clk_i      (upf_clk),
            .rst_i      (soc_reset),
            .sleep_req_i(soc_sleep_req[g]),
            .wake_req_i (soc_wake_req[g]),
            .ack_i      (soc_pwr_ack[g]),
            .err_clr_i  (soc_err_clr[g]),
            .pwr_en_o   (soc_pwr_en[g]),
            .iso_en_o   (soc_iso_en[g]),
            .save_o     (soc_save[g]),
            .restore_o  (soc_restore[g]),
            .state_o    (soc_pd_state[3*g +: 3]),
            .err_o      (soc_err[g]),
            .busy_o     (busy_w[g])
        );
    end

    assign soc_busy = |busy_w;
endmodule

// File: tb/tb_lp_pd_sequencer.sv
// Directed bench for lp_pd_sequencer: stimulus schedules expected outputs per
// cycle into a scoreboard queue, a negedge monitor retires and compares them.
module tb_lp_pd_sequencer;
    localparam int NUM_PD = 4;
    localparam int K_ST = 0, K_PWR = 1, K_ISO = 2, K_SAV = 3, K_RST = 4, K_ERR = 5, K_BSY = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_PD-1:0]    sleep, wake, ack, eclr;
    logic [NUM_PD-1:0]    pwr_en, iso_en, save, restore, err;
    logic [3*NUM_PD-1:0]  pd_state;
    logic                 busy;

    lp_pd_sequencer #(.NUM_PD(NUM_PD), .SETTLE_CYC(4), .TIMEOUT_CYC(16)) dut (
        .upf_clk      (clk),
        .soc_reset    (rst),
        .soc_sleep_req(sleep),
        .soc_wake_req (wake),
        .soc_pwr_ack  (ack),
        .soc_err_clr  (eclr),
        .soc_pwr_en   (pwr_en),
        .soc_iso_en   (iso_en),
        .soc_save     (save),
        .soc_restore  (restore),
        .soc_pd_state (pd_state),
        .soc_err      (err),
        .soc_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          d;
        logic [11:0] val;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] sample(int kind, int d);
        logic [3:0] v;
        v = '0;
        case (kind)
            K_ST:    return (d < 0) ? pd_state : {9'd0, pd_state[3*d +: 3]};
            K_PWR:   v = pwr_en;
            K_ISO:   v = iso_en;
            K_SAV:   v = save;
            K_RST:   v = restore;
            K_ERR:   v = err;
            default: return {11'd0, busy};
        endcase
        return (d < 0) ? {8'd0, v} : {11'd0, v[d]};
    endfunction

    // Monitor: outputs after edge N are observed at the following negedge.
    always @(negedge clk) begin
        logic [11:0] act;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                n_cmp++;
                act = sample(sbq[i].kind, sbq[i].d);
                if (sbq[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL k%0d[%0d]@%0d: expectation not retired in its cycle (now %0d)",
                             sbq[i].kind, sbq[i].d, sbq[i].cyc, cyc);
                end else if (act !== sbq[i].val) begin
                    n_bad++;
                    $display("FAIL k%0d[%0d]@%0d: got %0h want %0h",
                             sbq[i].kind, sbq[i].d, sbq[i].cyc, act, sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    function automatic void ex(int c, int kind, int d, int v);
        exp_t e;
        e.cyc = c; e.kind = kind; e.d = d; e.val = 12'(v);
        sbq.push_back(e);
    endfunction

    function automatic void ex_all_on(int c);
        ex(c, K_ST, -1, 0);    ex(c, K_PWR, -1, 'hF); ex(c, K_ISO, -1, 0);
        ex(c, K_SAV, -1, 0);   ex(c, K_RST, -1, 0);   ex(c, K_ERR, -1, 0);
        ex(c, K_BSY, 0, 0);
    endfunction

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; sleep = 4'b0100; wake = '0; ack = 4'hF; eclr = '0;

        // Reset state, request held through reset acted on only after release.
        goto(2);  ex_all_on(2); ex(3, K_ST, 2, 1); rst = 1'b0;
        goto(3);  sleep = '0; rst = 1'b1;
        goto(4);  ex_all_on(4); rst = 1'b0;

        // Power-down of domain 1, k = 7; wake pulse during ISO is ignored.
        goto(6);  sleep[1] = 1'b1;
        ex(7, K_ST, 1, 1);  ex(7, K_ISO, 1, 1);  ex(7, K_BSY, 0, 1);
        ex(8, K_ST, 1, 1);  ex(9, K_ST, 1, 1);
        ex(10, K_ST, 1, 1); ex(10, K_SAV, 1, 0);
        ex(11, K_ST, 1, 2); ex(11, K_SAV, 1, 1);
        ex(14, K_ST, 1, 2); ex(14, K_SAV, 1, 1); ex(14, K_PWR, 1, 1);
        ex(15, K_ST, 1, 3); ex(15, K_SAV, 1, 0); ex(15, K_PWR, 1, 0); ex(15, K_ISO, 1, 1);
        ex(16, K_ST, 1, 3);
        ex(17, K_ST, -1, 'h020); ex(17, K_PWR, -1, 'hD); ex(17, K_ISO, -1, 'h2);
        ex(17, K_BSY, 0, 0);     ex(17, K_ERR, -1, 0);
        goto(7);  sleep[1] = 1'b0; wake[1] = 1'b1;
        goto(9);  wake[1] = 1'b0;
        goto(16); ack[1] = 1'b0;

        // Power-up of domain 1, k = 20, ack returns 3 cycles into PUP.
        goto(19); wake[1] = 1'b1;
        ex(20, K_ST, 1, 5); ex(20, K_PWR, 1, 1); ex(20, K_ISO, 1, 1); ex(20, K_BSY, 0, 1);
        ex(22, K_ST, 1, 5);
        ex(23, K_ST, 1, 6); ex(23, K_RST, 1, 1);
        ex(26, K_ST, 1, 6); ex(26, K_RST, 1, 1);
        ex(27, K_ST, 1, 7); ex(27, K_RST, 1, 0); ex(27, K_ISO, 1, 1);
        ex(30, K_ST, 1, 7);
        ex_all_on(31);
        goto(20); wake[1] = 1'b0;
        goto(22); ack[1] = 1'b1;

        // Down again, then power-up timeout (16 cycles) and error clear.
        goto(33); sleep[1] = 1'b1;
        ex(42, K_ST, 1, 3); ex(43, K_ST, 1, 4); ex(43, K_ERR, 1, 0);
        goto(34); sleep[1] = 1'b0; ack[1] = 1'b0;
        goto(45); wake[1] = 1'b1;
        ex(46, K_ST, 1, 5);
        ex(61, K_ST, 1, 5); ex(61, K_ERR, 1, 0);
        ex(62, K_ST, 1, 4); ex(62, K_ERR, 1, 1); ex(62, K_BSY, 0, 0); ex(62, K_PWR, 1, 0);
        ex(63, K_ERR, 1, 1);
        ex(64, K_ERR, -1, 0); ex(64, K_ST, 1, 4);
        goto(46); wake[1] = 1'b0;
        goto(63); eclr[1] = 1'b1;
        goto(64); eclr[1] = 1'b0;

        // Reset from OFF.
        goto(66); ack = 4'hF; rst = 1'b1;
        ex_all_on(67);
        goto(67); rst = 1'b0;

        // All four domains down together, k = 70; domain 3 acks late.
        goto(69); sleep = 4'hF;
        ex(70, K_ST, -1, 'h249); ex(70, K_ISO, -1, 'hF); ex(70, K_BSY, 0, 1);
        ex(74, K_ST, -1, 'h492); ex(74, K_SAV, -1, 'hF);
        ex(78, K_ST, -1, 'h6DB); ex(78, K_PWR, -1, 0); ex(78, K_SAV, -1, 0);
        ex(79, K_ST, -1, 'h724); ex(79, K_BSY, 0, 1);
        ex(80, K_BSY, 0, 1);
        ex(81, K_ST, -1, 'h924); ex(81, K_BSY, 0, 0); ex(81, K_PWR, -1, 0); ex(81, K_ISO, -1, 'hF);
        goto(70); sleep = '0;
        goto(78); ack = 4'b1000;
        goto(80); ack = '0;

        // Reset while every domain is in SAVE.
        goto(83); ack = 4'hF; rst = 1'b1;
        ex(84, K_ST, -1, 0);
        goto(84); rst = 1'b0;
        goto(85); sleep = 4'hF;
        ex(90, K_ST, -1, 'h492);
        ex(91, K_ST, -1, 'h492); ex(91, K_SAV, -1, 'hF);
        ex_all_on(92);
        goto(86); sleep = '0;
        goto(91); rst = 1'b1;
        goto(92); rst = 1'b0;

        // Sleep held through OFF and power-up: ignored until ON, then re-enters ISO.
        goto(94); sleep[1] = 1'b1;
        ex(103, K_ST, 1, 3); ex(104, K_ST, 1, 4); ex(105, K_ST, 1, 4);
        ex(106, K_ST, 1, 5); ex(107, K_ST, 1, 6); ex(111, K_ST, 1, 7);
        ex(115, K_ST, 1, 0); ex(115, K_ISO, 1, 0);
        ex(116, K_ST, 1, 1); ex(116, K_ISO, 1, 1);
        goto(102); ack[1] = 1'b0;
        goto(105); wake[1] = 1'b1;
        goto(106); wake[1] = 1'b0; ack[1] = 1'b1;
        goto(116); sleep[1] = 1'b0;

        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lp_pd_sequencer.md
LP_PD_SEQUENCER -- requirements
Module: lp_pd_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PD, default 4: number of independently sequenced power domains, range 1..16.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 4: dwell cycles in each ISO, SAVE, RESTORE and DEISO state, minimum 1.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles to wait for switch ack, greater than SETTLE_CYC.
REQ-004 The block SHALL have port upf_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port soc_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port soc_sleep_req, input, NUM_PD bits: per-domain level request to power down.
REQ-007 The block SHALL have port soc_wake_req, input, NUM_PD bits: per-domain level request to power up.
REQ-008 The block SHALL have port soc_pwr_ack, input, NUM_PD bits: power-switch status, 1 = rail up.
REQ-009 The block SHALL have port soc_err_clr, input, NUM_PD bits: per-domain error clear.
REQ-010 The block SHALL have port soc_pwr_en, output, NUM_PD bits: power-switch enable.
REQ-011 The block SHALL have port soc_iso_en, output, NUM_PD bits: isolation-clamp enable.
REQ-012 The block SHALL have port soc_save, output, NUM_PD bits: retention-save strobe.
REQ-013 The block SHALL have port soc_restore, output, NUM_PD bits: retention-restore strobe.
REQ-014 The block SHALL have port soc_pd_state, output, 3*NUM_PD bits: per-domain state code, domain i in bits [3i+2:3i].
REQ-015 The block SHALL have port soc_err, output, NUM_PD bits: sticky per-domain ack-timeout flag.
REQ-016 The block SHALL have port soc_busy, output, 1 bit: OR over domains not in ON or OFF.

Function
REQ-017 Each domain SHALL run an independent FSM with codes ON=0, ISO=1, SAVE=2, PDOWN=3, OFF=4, PUP=5, RESTORE=6, DEISO=7, plus its own dwell/timeout counter of width $clog2(TIMEOUT_CYC+1).
REQ-018 Outputs SHALL be a Moore decode of registered state: pwr_en=1 in ON, ISO, SAVE, PUP, RESTORE, DEISO; iso_en=1 in every state except ON; save=1 only in SAVE; restore=1 only in RESTORE.
REQ-019 In ON, a 1 sampled on sleep_req[i] SHALL move domain i to ISO on that edge; wake_req[i] SHALL be ignored in ON.
REQ-020 ISO, SAVE, RESTORE and DEISO SHALL each last exactly SETTLE_CYC cycles, then advance ISO->SAVE->PDOWN and RESTORE->DEISO->ON.
REQ-021 In PDOWN, ack[i]=0 sampled SHALL move the domain to OFF on that edge; if ack stays 1 for TIMEOUT_CYC cycles, the domain SHALL go to OFF and set err[i].
REQ-022 In OFF, a 1 sampled on wake_req[i] SHALL move the domain to PUP on that edge; sleep_req[i] SHALL be ignored in OFF.
REQ-023 In PUP, ack[i]=1 sampled SHALL move the domain to RESTORE; if ack stays 0 for TIMEOUT_CYC cycles, the domain SHALL return to OFF and set err[i].
REQ-024 Requests arriving in transitional states (ISO..PDOWN, PUP..DEISO) SHALL be ignored; sequences always complete, and a request still held on return to ON/OFF is then honoured.
REQ-025 With sleep_req and wake_req both high, only the request legal for the current state SHALL take effect.
REQ-026 Once set, err[i] SHALL stay set until err_clr[i]=1; if set and clear coincide, set SHALL win.
REQ-027 The counter SHALL clear on every state entry and SHALL saturate, never wrap.

Reset
REQ-028 When soc_reset=1 at an edge, every domain SHALL enter ON with pwr_en=all 1, iso_en=0, save=0, restore=0, err=0, busy=0, counters 0, regardless of in-flight state, including reset mid-sequence.
REQ-029 Requests held high during reset SHALL be acted on no earlier than the first edge after reset deasserts.

Verification
REQ-030 Bench SHALL check power-down with NUM_PD=4, SETTLE_CYC=4 and sleep_req[1] rising at edge k: iso_en[1]=1 from k, save[1]=1 for k+4..k+7, pwr_en[1]=0 from k+8; ack[1]=0 at k+10 gives state OFF(4).
REQ-031 Bench SHALL check power-up: from OFF, pulse wake_req[1] with ack returning after 3 cycles, expecting RESTORE for 4 cycles, DEISO for 4 cycles, then ON with iso_en[1]=0.
REQ-032 Bench SHALL check timeout with TIMEOUT_CYC=16: PUP with ack held 0 gives OFF with err[1]=1 after 16 cycles; err_clr[1] then clears err[1].
REQ-033 Bench SHALL check concurrency: sleep_req=4'b1111 at once gives all domains sequencing identically and busy=1 until all reach OFF.
REQ-034 Bench SHALL check reset mid-operation: soc_reset in SAVE gives all domains ON, pwr_en=4'b1111, iso_en=0 at the next edge.
REQ-035 Bench SHALL check ignored requests: wake_req during ISO has no effect; sleep_req held through power-up re-enters ISO the edge after ON.
